sw_debounce: RTL and testbench

Input conditioning stage for the board slide switches, directly upstream of the LED/counter logic. Synchronises each raw switch into the CLK100MHZ domain with a 2-FF chain. A per-channel stability counter filters bounce. Produces clean levels plus single-cycle rise/fall strobes that downstream logic consumes in place of raw SW.

---
 rtl/sw_debounce.sv | 125 ++++++++++++
 tb/tb_sw_debounce.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: 2-FF synchroniser, per-channel stability filter, rise/fall strobes.
// Optional toggle latches are built only when SW_DEBOUNCE_TOGGLE_EN is defined.
module sw_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_BUSY,
  output logic [WIDTH-1:0] SW_TOGGLE
);

  localparam logic [0:0]       ST_STABLE   = 1'b0;
  localparam logic [0:0]       ST_COUNTING = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] db_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [WIDTH-1:0] counting_nxt;

  // Two-flop synchroniser; only sync2 is allowed to reach the filter.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_d;
    logic             rise_d;
    logic             fall_d;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Counter tracks consecutive mismatch edges; it never exceeds CNT_LAST.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = SW_DB[i];
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (sync2[i] != SW_DB[i]) begin
            state_d = ST_COUNTING;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          if (sync2[i] == SW_DB[i]) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            db_d    = sync2[i];
            rise_d  = sync2[i];
            fall_d  = ~sync2[i];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end

    assign db_nxt[i]       = db_d;
    assign rise_nxt[i]     = rise_d;
    assign fall_nxt[i]     = fall_d;
    assign counting_nxt[i] = (state_d == ST_COUNTING);
  end

  // Busy follows the channel states exactly, so it drops on the accept edge.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      SW_DB   <= '0;
      SW_RISE <= '0;
      SW_FALL <= '0;
      SW_BUSY <= 1'b0;
    end else begin
      SW_DB   <= db_nxt;
      SW_RISE <= rise_nxt;
      SW_FALL <= fall_nxt;
      SW_BUSY <= |counting_nxt;
    end
  end

`ifdef SW_DEBOUNCE_TOGGLE_EN
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      SW_TOGGLE <= '0;
    end else begin
      SW_TOGGLE <= SW_TOGGLE ^ SW_RISE;
    end
  end
`else
  assign SW_TOGGLE = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=8, CNT_W=4.
module tb_sw_debounce;

  localparam int unsigned WIDTH = 4;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  localparam bit TOGGLE_EN = 1'b1;
`else
  localparam bit TOGGLE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_busy;
  logic [WIDTH-1:0] sw_toggle;

  int n_checks = 0;
  int n_fail   = 0;

  sw_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .SW        (sw),
    .SW_DB     (sw_db),
    .SW_RISE   (sw_rise),
    .SW_FALL   (sw_fall),
    .SW_BUSY   (sw_busy),
    .SW_TOGGLE (sw_toggle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = '0;
    repeat (3) tick();
    n_checks++;
    if ({sw_db, sw_rise, sw_fall, sw_busy, sw_toggle} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got db=%b rise=%b fall=%b busy=%b tog=%b want all 0",
               sw_db, sw_rise, sw_fall, sw_busy, sw_toggle);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({sw_db, sw_busy} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_idle got db=%b busy=%b want 0", sw_db, sw_busy);
    end
  endtask

  task automatic test_clean_edge();
    int busy_cycles = 0;
    sw[0] = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (sw_busy) busy_cycles++;
      n_checks++;
      if (sw_db[0] !== (e >= 10)) begin
        n_fail++;
        $display("FAIL clean_db e=%0d got %b want %b", e, sw_db[0], (e >= 10));
      end
      n_checks++;
      if (sw_rise[0] !== (e == 10)) begin
        n_fail++;
        $display("FAIL clean_rise e=%0d got %b want %b", e, sw_rise[0], (e == 10));
      end
      n_checks++;
      if (sw_busy !== (e >= 3 && e <= 9)) begin
        n_fail++;
        $display("FAIL clean_busy e=%0d got %b want %b", e, sw_busy, (e >= 3 && e <= 9));
      end
    end
    n_checks++;
    if (busy_cycles != 7) begin
      n_fail++;
      $display("FAIL clean_busy_len got %0d want 7", busy_cycles);
    end
  endtask

  task automatic test_bounce();
    int rises = 0;
    for (int p = 0; p < 4; p++) begin
      sw[1] = (p % 2 == 0);
      for (int e = 0; e < 3; e++) begin
        tick();
        n_checks++;
        if (sw_rise[1] !== 1'b0 || sw_fall[1] !== 1'b0 || sw_db[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL bounce_quiet p=%0d got rise=%b fall=%b db=%b want 0 0 0",
                   p, sw_rise[1], sw_fall[1], sw_db[1]);
        end
      end
    end
    sw[1] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (sw_rise[1]) rises++;
      n_checks++;
      if (sw_db[1] !== (e >= 10)) begin
        n_fail++;
        $display("FAIL bounce_db e=%0d got %b want %b", e, sw_db[1], (e >= 10));
      end
      n_checks++;
      if (sw_rise[1] !== (e == 10)) begin
        n_fail++;
        $display("FAIL bounce_rise e=%0d got %b want %b", e, sw_rise[1], (e == 10));
      end
    end
    n_checks++;
    if (rises != 1 || sw_db !== 4'b0011) begin
      n_fail++;
      $display("FAIL bounce_summary got rises=%0d db=%b want 1 0011", rises, sw_db);
    end
  endtask

  task automatic test_release();
    sw[2] = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (sw_db[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL release_setup got db2=%b want 1", sw_db[2]);
    end
    sw[2] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      n_checks++;
      if (sw_fall[2] !== (e == 10)) begin
        n_fail++;
        $display("FAIL release_fall e=%0d got %b want %b", e, sw_fall[2], (e == 10));
      end
      n_checks++;
      if (sw_rise[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL release_rise e=%0d got %b want 0", e, sw_rise[2]);
      end
      n_checks++;
      if (sw_db[2] !== (e < 10)) begin
        n_fail++;
        $display("FAIL release_db e=%0d got %b want %b", e, sw_db[2], (e < 10));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] exp_rise;
    logic [WIDTH-1:0] exp_db;
    sw = '0;
    repeat (12) tick();
    n_checks++;
    if (sw_db !== 4'h0) begin
      n_fail++;
      $display("FAIL simul_setup got db=%b want 0000", sw_db);
    end
    sw = 4'hF;
    for (int e = 1; e <= 11; e++) begin
      tick();
      exp_rise = (e == 10) ? 4'hF : 4'h0;
      exp_db   = (e >= 10) ? 4'hF : 4'h0;
      n_checks++;
      if (sw_rise !== exp_rise || sw_db !== exp_db || sw_fall !== 4'h0) begin
        n_fail++;
        $display("FAIL simul e=%0d got rise=%b db=%b fall=%b want %b %b 0000",
                 e, sw_rise, sw_db, sw_fall, exp_rise, exp_db);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] exp_rise;
    logic [WIDTH-1:0] exp_db;
    sw = 4'h0;
    repeat (7) tick();
    n_checks++;
    if (sw_busy !== 1'b1 || sw_db !== 4'hF) begin
      n_fail++;
      $display("FAIL areset_pre got busy=%b db=%b want 1 1111", sw_busy, sw_db);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sw_db, sw_rise, sw_fall, sw_busy, sw_toggle} !== 17'd0) begin
      n_fail++;
      $display("FAIL areset_async got db=%b rise=%b fall=%b busy=%b tog=%b want all 0",
               sw_db, sw_rise, sw_fall, sw_busy, sw_toggle);
    end
    sw = 4'b1000;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      exp_rise = (e == 10) ? 4'b1000 : 4'b0000;
      exp_db   = (e >= 10) ? 4'b1000 : 4'b0000;
      n_checks++;
      if (sw_rise !== exp_rise || sw_db !== exp_db || sw_busy !== (e >= 3 && e <= 9)) begin
        n_fail++;
        $display("FAIL areset_reaccept e=%0d got rise=%b db=%b busy=%b want %b %b %b",
                 e, sw_rise, sw_db, sw_busy, exp_rise, exp_db, (e >= 3 && e <= 9));
      end
    end
  endtask

  task automatic test_toggle();
    logic tog_state = 1'b0;
    logic exp_tog;
    for (int p = 0; p < 3; p++) begin
      sw[0] = 1'b1;
      for (int e = 1; e <= 11; e++) begin
        tick();
        exp_tog = TOGGLE_EN & ((e >= 11) ? ~tog_state : tog_state);
        n_checks++;
        if (sw_toggle[0] !== exp_tog || sw_toggle[3:1] !== 3'b000) begin
          n_fail++;
          $display("FAIL toggle p=%0d e=%0d got %b want 000%b", p, e, sw_toggle, exp_tog);
        end
      end
      tog_state = ~tog_state;
      sw[0] = 1'b0;
      repeat (12) tick();
      n_checks++;
      if (sw_toggle[0] !== (TOGGLE_EN & tog_state) || sw_db[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle_hold p=%0d got tog=%b db0=%b want %b 0",
                 p, sw_toggle[0], sw_db[0], TOGGLE_EN & tog_state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_release();
    test_simultaneous();
    test_async_reset();
    test_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
